// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU fetch package.
// Holds the fetch FSM state encoding, the default bubble instruction, the
// halfword PC increment and a helper that forces halfword alignment.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [15:0] NOP_INSN_DEF = 16'hBF00;
    localparam logic [31:0] HW_INC       = 32'd2;

    function automatic logic [31:0] hw_align(input logic [31:0] a);
        return {a[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_perf.sv
// Fetch performance counters (only built when FETCH_CTRL_PERF_EN is defined).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   deliver_i        an instruction is being presented with valid=1
//   bubble_i         the fetch unit is emitting a flush NOP this cycle
//   o_fetch_cnt_r    saturating count of delivered instructions
//   o_bubble_cnt_r   saturating count of flush NOP cycles
`ifdef FETCH_CTRL_PERF_EN
module fetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        deliver_i,
    input  logic        bubble_i,
    output logic [31:0] o_fetch_cnt_r,
    output logic [15:0] o_bubble_cnt_r
);

    logic [31:0] fetch_cnt_q;
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (deliver_i && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (bubble_i && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign o_fetch_cnt_r  = fetch_cnt_q;
    assign o_bubble_cnt_r = bubble_cnt_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer feeding the 16-bit decoder input.
// Owns the PC, runs a req/ack handshake with instruction memory, parks a
// fetched halfword while the pipeline stalls, and injects NOP bubbles after
// a taken branch.
// Optional feature macro: FETCH_CTRL_PERF_EN adds o_fetch_cnt_r/o_bubble_cnt_r.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_stall            downstream cannot accept a new instruction
//   i_branch           taken-branch pulse, i_branch_target its destination
//   o_imem_req/addr    fetch request and halfword-aligned address
//   i_imem_ack/data    memory accept + returned halfword (same cycle)
//   o_ir_r/valid_r     instruction to decoder, valid when newly delivered
//   o_pc_r             address of the next instruction to fetch
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [15:0] NOP_INSN     = NOP_INSN_DEF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic [31:0] i_branch_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic [15:0] o_ir_r,
    output logic        o_ir_valid_r,
    output logic [31:0] o_pc_r
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt_r,
    output logic [15:0] o_bubble_cnt_r
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_e   state_q;
    logic           req_q;
    logic [31:0]    addr_q;
    logic [31:0]    pc_q;
    logic [15:0]    ir_q;
    logic           valid_q;
    logic [15:0]    hold_q;
    logic           pend_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] pc_inc_d;
    logic        pend_d;
    logic        unused_tgt_lsb;

    assign pc_inc_d       = pc_q + HW_INC;   // wraps modulo 2^32
    assign unused_tgt_lsb = i_branch_target[0];
    // A request still outstanding when a branch arrives must be completed
    // on the bus (address held) but its data thrown away.
    assign pend_d         = req_q && !i_imem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSN;
            valid_q <= 1'b0;
            hold_q  <= NOP_INSN;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (i_branch) begin
            // Branch beats stall and ack; addr_q is left on any pending request.
            state_q <= ST_FLUSH;
            pc_q    <= hw_align(i_branch_target);
            ir_q    <= NOP_INSN;
            valid_q <= 1'b0;
            hold_q  <= NOP_INSN;
            cnt_q   <= CNT_INIT;
            pend_q  <= pend_d;
            req_q   <= pend_d;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                ST_REQ: begin
                    if (i_stall) begin
                        if (i_imem_ack) begin
                            hold_q  <= i_imem_data;
                            pc_q    <= pc_inc_d;
                            addr_q  <= pc_inc_d;
                            valid_q <= 1'b0;
                            req_q   <= 1'b0;
                            state_q <= ST_HOLD;
                        end
                    end else if (i_imem_ack) begin
                        ir_q    <= i_imem_data;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                        addr_q  <= pc_inc_d;
                    end else begin
                        ir_q    <= NOP_INSN;
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        ir_q    <= hold_q;
                        valid_q <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CNT_W'(1);
                    if (pend_q && i_imem_ack) begin
                        pend_q <= 1'b0;
                        req_q  <= 1'b0;
                    end
                    if ((cnt_q == '0) && !pend_q) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_imem_req   = req_q;
    assign o_imem_addr  = addr_q;
    assign o_ir_r       = ir_q;
    assign o_ir_valid_r = valid_q;
    assign o_pc_r       = pc_q;

`ifdef FETCH_CTRL_PERF_EN
    fetch_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .deliver_i      (valid_q),
        .bubble_i       (state_q == ST_FLUSH),
        .o_fetch_cnt_r  (o_fetch_cnt_r),
        .o_bubble_cnt_r (o_bubble_cnt_r)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [15:0] NOP = 16'hBF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, ack;
    logic [31:0] tgt;
    logic [15:0] data;
    logic        req, valid;
    logic [31:0] addr, pc;
    logic [15:0] ir;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt;
    logic [15:0] bubble_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall),
        .i_branch        (branch),
        .i_branch_target (tgt),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_data     (data),
        .o_ir_r          (ir),
        .o_ir_valid_r    (valid),
        .o_pc_r          (pc)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .o_fetch_cnt_r   (fetch_cnt),
        .o_bubble_cnt_r  (bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One memory-accept cycle: checks the request on the bus, acks it and,
    // when the data is meant to reach the decoder, queues it for the monitor.
    task automatic ack_cycle(input logic [31:0] exp_addr, input logic [15:0] d, input bit deliver);
        chk("ack_req", {31'd0, req}, 32'd1);
        chk("ack_addr", addr, exp_addr);
        ack  = 1'b1;
        data = d;
        if (deliver) exp_q.push_back(d);
        step();
        ack = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_req"}, {31'd0, req}, 32'd0);
        chk({tag, "_ir"}, {16'd0, ir}, {16'd0, NOP});
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    // Scoreboard monitor: every delivered instruction must match the oldest
    // expected one; a delivery with nothing expected is a failure.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL deliver_unexpected: got %h expected none", ir);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (ir !== e) begin
                    fails++;
                    $display("FAIL deliver: got %h expected %h", ir, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; ack = 1'b0; tgt = '0; data = '0;
        step(); step();
        chk_reset_state("reset");
        rst = 1'b0;
        chk("idle_req", {31'd0, req}, 32'd0);      // one IDLE cycle
        step();

        // Zero-wait streaming
        ack_cycle(32'h0, 16'h2001, 1'b1);
        ack_cycle(32'h2, 16'h2102, 1'b1);
        ack_cycle(32'h4, 16'h2203, 1'b1);

        // Stall for three cycles, ack on the first
        stall = 1'b1;
        ack_cycle(32'h6, 16'h4608, 1'b1);
        chk("hold_ir", {16'd0, ir}, 32'h2203);
        chk("hold_valid", {31'd0, valid}, 32'd0);
        chk("hold_req", {31'd0, req}, 32'd0);
        chk("hold_pc", pc, 32'h8);
        step();
        chk("hold_ir2", {16'd0, ir}, 32'h2203);
        step();
        chk("hold_ir3", {16'd0, ir}, 32'h2203);
        stall = 1'b0;
        step();
        chk("post_hold_req", {31'd0, req}, 32'd1);
        chk("post_hold_addr", addr, 32'h8);
        step();
        chk("no_dup_ir", {16'd0, ir}, {16'd0, NOP});
        chk("no_dup_valid", {31'd0, valid}, 32'd0);

        // Branch while request to 0x8 is unacked; ack 4 cycles later
        branch = 1'b1; tgt = 32'h40;
        step();
        branch = 1'b0;
        chk("pend_pc", pc, 32'h40);
        chk("pend_req", {31'd0, req}, 32'd1);
        chk("pend_addr", addr, 32'h8);
        chk("pend_ir", {16'd0, ir}, {16'd0, NOP});
        step();
        chk("pend_addr2", addr, 32'h8);
        step();
        chk("pend_req3", {31'd0, req}, 32'd1);
        step();
        ack = 1'b1; data = 16'hDEAD;   // discarded
        step();
        ack = 1'b0;
        chk("pend_done_req", {31'd0, req}, 32'd0);
        step();
        ack_cycle(32'h40, 16'h1111, 1'b1);

        // Branch coincident with ack: data dropped, no pending request
        branch = 1'b1; tgt = 32'h0000_0101; ack = 1'b1; data = 16'hBEEF;
        step();
        branch = 1'b0; ack = 1'b0;
        chk("br_pc", pc, 32'h100);
        chk("br_req", {31'd0, req}, 32'd0);
        chk("br_ir", {16'd0, ir}, {16'd0, NOP});
        chk("br_valid", {31'd0, valid}, 32'd0);
        step();
        chk("br_req2", {31'd0, req}, 32'd0);
        chk("br_ir2", {16'd0, ir}, {16'd0, NOP});
        step();
        ack_cycle(32'h100, 16'h2304, 1'b1);

        // Branch and stall together: stall has no effect during flush
        stall = 1'b1; branch = 1'b1; tgt = 32'h200; ack = 1'b1; data = 16'hCAFE;
        step();
        branch = 1'b0; ack = 1'b0;
        chk("bs_pc", pc, 32'h200);
        chk("bs_valid", {31'd0, valid}, 32'd0);
        step();
        step();
        stall = 1'b0;
        ack_cycle(32'h200, 16'h3005, 1'b1);

        // PC wrap at the top of the address space
        branch = 1'b1; tgt = 32'hFFFF_FFFF; ack = 1'b1; data = 16'h7777;
        step();
        branch = 1'b0; ack = 1'b0;
        chk("wrap_pc_align", pc, 32'hFFFF_FFFE);
        step();
        step();
        ack_cycle(32'hFFFF_FFFE, 16'h4444, 1'b1);
        chk("wrap_pc", pc, 32'h0);
        ack_cycle(32'h0, 16'h4545, 1'b1);

        // Reset during REQ, late ack in the following IDLE cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("midrst");
        ack = 1'b1; data = 16'h5555;   // must be ignored
        step();
        ack = 1'b0;
        chk("late_ack_valid", {31'd0, valid}, 32'd0);
        chk("late_ack_ir", {16'd0, ir}, {16'd0, NOP});
        ack_cycle(32'h0, 16'h6006, 1'b1);
        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer that drives the decoder's 16-bit instruction input. Owns the program counter and runs a request/acknowledge handshake with instruction memory. Holds fetched instructions while the pipeline stalls. On a taken branch, it flushes the pipeline by inserting NOP bubbles that cover the decoder's two-stage destination-address pipeline.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC and first fetch address after reset
- NOP_INSN, 16'hBF00, instruction injected as a bubble
- FLUSH_CYCLES, 2, bubbles inserted per branch (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_stall  in  1  downstream cannot accept a new instruction
- i_branch  in  1  taken branch, one-cycle pulse
- i_branch_target  in  32  branch destination
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  fetch address, halfword aligned
- i_imem_ack  in  1  memory accepted request; data valid this cycle
- i_imem_data  in  16  fetched halfword
- o_ir_r  out  16  instruction to decoder
- o_ir_valid_r  out  1  o_ir_r holds a newly delivered instruction
- o_pc_r  out  32  address of next instruction to fetch

## Operation
FSM with states IDLE, REQ, HOLD, FLUSH. o_imem_req is high in REQ, and in FLUSH while a discarded request is pending.

- IDLE (after reset): req=0. Next state REQ. i_branch here → FLUSH.
- REQ: req=1, addr stable until ack.
  - ack & !stall: o_ir_r←data, valid←1, o_pc_r and addr += 2.
  - ack & stall: hold_r←data, pc += 2, valid←0, o_ir_r frozen, → HOLD.
  - no ack, !stall: o_ir_r←NOP_INSN, valid←0.
  - no ack, stall: outputs frozen, req held.
- HOLD: req=0, outputs frozen while stall. On !stall: o_ir_r←hold_r, valid←1, → REQ.
- FLUSH (on i_branch in any state): o_pc_r←{target[31:1],1'b0}, o_ir_r←NOP_INSN, valid←0, bubble counter←FLUSH_CYCLES-1, hold_r discarded.
  - If in REQ without ack that cycle: set pend_r, keep req and old addr until ack, drop the returned data.
  - Exit to REQ with addr←o_pc_r when counter=0 and pend_r=0.
  - i_stall is ignored in FLUSH.
- Priority: rst > i_branch > i_stall > ack.
  - Branch coincident with ack: data dropped, no pend.
  - Branch during FLUSH restarts the counter with the new target.
- PC arithmetic is modulo 2^32 (0xFFFF_FFFE + 2 → 0). Bit 0 of addr and pc is always 0.
- i_imem_ack while o_imem_req=0 is ignored.

## Timing
- Reset values: o_pc_r=RESET_PC, o_imem_addr=RESET_PC, o_imem_req=0, o_ir_r=NOP_INSN, o_ir_valid_r=0, state IDLE, pend_r=0, counter=0.
- First req asserts on the second cycle after rst deasserts (one IDLE cycle).
- Ack in cycle n → o_ir_r/valid in n+1, next request (addr+2) visible in n+1. Throughput is 1 instr/cycle with zero-wait memory.
- Branch in cycle n with no pending request → NOP from n+1 for FLUSH_CYCLES cycles. Request to the target asserts in n+1+FLUSH_CYCLES.
- Reset mid-operation aborts the FSM. A late ack after reset is ignored (IDLE).

## Configuration
FETCH_CTRL_PERF_EN:
- Defined: adds o_fetch_cnt_r[31:0], incremented per delivered instruction (valid=1), and o_bubble_cnt_r[15:0], incremented per flush NOP cycle. Both saturate and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared CPU package: fetch state enum, NOP_INSN, halfword increment constant.
- FSM, PC and hold register live in one module; no sub-modules.
- Perf counters go in an optional sub-module fetch_perf, instantiated under the macro.

## Test plan
- Reset, zero-wait memory returning 0x2001,0x2102,0x2203 → addr 0,2,4. o_ir_r shows the same sequence one cycle after each ack, valid=1 each.
- i_stall high 3 cycles, ack on the first stall cycle with 0x4608 → o_ir_r frozen, then 0x4608 delivered the cycle after stall drops, no duplicate/loss.
- i_branch with target 0x0000_0101 → o_pc_r=0x100, 2 NOP cycles valid=0, next req addr 0x100.
- i_branch while the request to 0x8 is unacked, ack 4 cycles later → req held at addr 0x8, data discarded, then req at target.
- i_branch and i_stall same cycle → branch taken, stall ignored during FLUSH.
- rst asserted during REQ, ack arriving the cycle after → all outputs at reset values, ack ignored, fetch restarts at RESET_PC.
